// File: rtl/wired_fpu_share_arb_pkg.sv
// Shared types and constants for the FPU share arbiter: request/response
// payloads carrying a tag, requester indices and the free-tag encoder.
package wired_fpu_share_arb_pkg;

  localparam int REQ_CNT         = 2;
  localparam int MAX_OUTSTANDING = 4;
  localparam int TAG_W           = $clog2(MAX_OUTSTANDING);
  localparam int REQ_IDX_W       = (REQ_CNT > 1) ? $clog2(REQ_CNT) : 1;

  // Requester indices: out-of-order FPU IQ and the in-order FCC/FCSR path
  localparam int FPU_ARB_REQ_OOO = 0;
  localparam int FPU_ARB_REQ_INO = 1;

  typedef logic [TAG_W-1:0]     fpu_tag_t;
  typedef logic [REQ_IDX_W-1:0] req_idx_t;

  typedef struct packed {
    logic [3:0]  op;
    logic [2:0]  rm;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [5:0]  robId;
    fpu_tag_t    tag;
  } iq_fpu_req_t;

  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  fflags;
    logic [5:0]  robId;
    fpu_tag_t    tag;
  } iq_fpu_resp_t;

  // Lowest-index clear bit of a busy vector; only meaningful when not all set
  function automatic fpu_tag_t firstZero(input logic [MAX_OUTSTANDING-1:0] busyVec);
    fpu_tag_t result;
    result = '0;
    for (int i = MAX_OUTSTANDING - 1; i >= 0; i--) begin
      if (!busyVec[i]) result = fpu_tag_t'(i);
    end
    return result;
  endfunction

endpackage

// File: rtl/wired_fpu_share_arb_tag_table.sv
// Tag bookkeeping for in-flight FPU ops: which tags are busy, who issued
// them, and which were orphaned by a flush and must be silently dropped.
module wired_fpu_tag_table
  import wired_fpu_share_arb_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       allocValid_i,
  input  fpu_tag_t                   allocTag_i,
  input  req_idx_t                   allocOwner_i,
  input  logic                       retireValid_i,
  input  fpu_tag_t                   retireTag_i,
  input  logic                       flush_i,
  output logic [MAX_OUTSTANDING-1:0] tagBusy_o,
  output logic [MAX_OUTSTANDING-1:0] tagStale_o,
  output req_idx_t                   tagOwner_o [MAX_OUTSTANDING],
  output fpu_tag_t                   freeTag_o,
  output logic                       full_o
);

  logic [MAX_OUTSTANDING-1:0] tagBusy_q, tagBusy_d;
  logic [MAX_OUTSTANDING-1:0] tagStale_q, tagStale_d;
  req_idx_t                   tagOwner_q [MAX_OUTSTANDING];
  req_idx_t                   tagOwner_d [MAX_OUTSTANDING];

  // Next-state: flush marks every busy tag stale, retire frees, alloc claims.
  // Alloc and retire never hit the same tag since alloc only sees free tags.
  always_comb begin
    tagBusy_d  = tagBusy_q;
    tagStale_d = tagStale_q;
    tagOwner_d = tagOwner_q;
    if (flush_i) tagStale_d = tagStale_q | tagBusy_q;
    if (retireValid_i) tagBusy_d[retireTag_i] = 1'b0;
    if (allocValid_i) begin
      tagBusy_d[allocTag_i]  = 1'b1;
      tagStale_d[allocTag_i] = 1'b0;
      tagOwner_d[allocTag_i] = allocOwner_i;
    end
  end

  // Table state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tagBusy_q  <= '0;
      tagStale_q <= '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) tagOwner_q[i] <= '0;
    end else begin
      tagBusy_q  <= tagBusy_d;
      tagStale_q <= tagStale_d;
      tagOwner_q <= tagOwner_d;
    end
  end

  assign tagBusy_o  = tagBusy_q;
  assign tagStale_o = tagStale_q;
  assign tagOwner_o = tagOwner_q;
  assign freeTag_o  = firstZero(tagBusy_q);
  assign full_o     = &tagBusy_q;

endmodule

// File: rtl/wired_fpu_share_arb.sv
// Shares one tagged out-of-order FPU between the issue queues: round-robin
// grant with a lock that holds an unaccepted offer stable, tag allocation,
// and tag-based routing of results back to the requester that issued them.
module wired_fpu_share_arb
  import wired_fpu_share_arb_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               flush_i,
  input  logic [REQ_CNT-1:0] req_valid_i,
  output logic [REQ_CNT-1:0] req_ready_o,
  input  iq_fpu_req_t        req_i [REQ_CNT],
  output logic [REQ_CNT-1:0] resp_valid_o,
  input  logic [REQ_CNT-1:0] resp_ready_i,
  output iq_fpu_resp_t       resp_o,
  output logic               fpu_valid_o,
  input  logic               fpu_ready_i,
  output iq_fpu_req_t        fpu_req_o,
  output fpu_tag_t           fpu_tag_o,
  input  logic               fpu_valid_i,
  output logic               fpu_ready_o,
  input  iq_fpu_resp_t       fpu_resp_i,
  input  fpu_tag_t           fpu_tag_i,
  output logic               busy_o
);

  logic [MAX_OUTSTANDING-1:0] tagBusy, tagStale;
  req_idx_t                   tagOwner [MAX_OUTSTANDING];
  fpu_tag_t                   freeTag;
  logic                       tagFull;

  req_idx_t rrPtr_q, rrPtr_d;
  logic     lockVld_q, lockVld_d;
  req_idx_t lockIdx_q, lockIdx_d;
  fpu_tag_t lockTag_q, lockTag_d;

  req_idx_t grantIdx;
  logic     grantVld;
  fpu_tag_t issueTag;
  logic     canIssue;
  logic     issueHs;
  req_idx_t respOwner;
  logic     retireValid;
  int       rrSum;

  // Pick the requester: a locked offer wins, otherwise the first valid
  // requester at or after the round-robin pointer
  always_comb begin
    grantIdx = rrPtr_q;
    grantVld = 1'b0;
    rrSum    = 0;
    if (lockVld_q) begin
      grantIdx = lockIdx_q;
      grantVld = req_valid_i[lockIdx_q];
    end else begin
      for (int k = REQ_CNT - 1; k >= 0; k--) begin
        rrSum = int'(rrPtr_q) + k;
        if (rrSum >= REQ_CNT) rrSum = rrSum - REQ_CNT;
        if (req_valid_i[req_idx_t'(rrSum)]) begin
          grantIdx = req_idx_t'(rrSum);
          grantVld = 1'b1;
        end
      end
    end
  end

  assign canIssue    = !flush_i && !tagFull;
  assign issueTag    = lockVld_q ? lockTag_q : freeTag;
  assign fpu_valid_o = canIssue && grantVld;
  assign fpu_req_o   = req_i[grantIdx];
  assign fpu_tag_o   = issueTag;
  assign issueHs     = fpu_valid_o && fpu_ready_i;

  // Only the granted requester sees ready, and only on a real handshake
  always_comb begin
    req_ready_o = '0;
    if (issueHs) req_ready_o[grantIdx] = 1'b1;
  end

  // Lock and round-robin next-state; flush abandons any pending offer
  always_comb begin
    lockVld_d = lockVld_q;
    lockIdx_d = lockIdx_q;
    lockTag_d = lockTag_q;
    rrPtr_d   = rrPtr_q;
    if (flush_i) begin
      lockVld_d = 1'b0;
    end else if (fpu_valid_o && !fpu_ready_i) begin
      lockVld_d = 1'b1;
      lockIdx_d = grantIdx;
      lockTag_d = issueTag;
    end else if (issueHs) begin
      lockVld_d = 1'b0;
    end
    if (issueHs) begin
      rrPtr_d = (grantIdx == req_idx_t'(REQ_CNT - 1)) ? '0 : req_idx_t'(grantIdx + 1'b1);
    end
  end

  // Arbiter state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rrPtr_q   <= '0;
      lockVld_q <= 1'b0;
      lockIdx_q <= '0;
      lockTag_q <= '0;
    end else begin
      rrPtr_q   <= rrPtr_d;
      lockVld_q <= lockVld_d;
      lockIdx_q <= lockIdx_d;
      lockTag_q <= lockTag_d;
    end
  end

  // Route a returning result to its owner; stale results are swallowed at
  // once so the FPU never stalls on work nobody is waiting for
  always_comb begin
    respOwner    = tagOwner[fpu_tag_i];
    resp_valid_o = '0;
    resp_o       = fpu_resp_i;
    fpu_ready_o  = fpu_valid_i;
    if (tagBusy[fpu_tag_i] && !tagStale[fpu_tag_i]) begin
      resp_valid_o[respOwner] = fpu_valid_i;
      fpu_ready_o             = resp_ready_i[respOwner];
    end else if (tagBusy[fpu_tag_i]) begin
      fpu_ready_o = 1'b1;
    end
  end

  assign retireValid = fpu_valid_i && fpu_ready_o && tagBusy[fpu_tag_i];
  assign busy_o      = |tagBusy;

  wired_fpu_tag_table uTagTable (
    .clk          (clk),
    .rst          (rst),
    .allocValid_i (issueHs),
    .allocTag_i   (issueTag),
    .allocOwner_i (grantIdx),
    .retireValid_i(retireValid),
    .retireTag_i  (fpu_tag_i),
    .flush_i      (flush_i),
    .tagBusy_o    (tagBusy),
    .tagStale_o   (tagStale),
    .tagOwner_o   (tagOwner),
    .freeTag_o    (freeTag),
    .full_o       (tagFull)
  );

  // A result may only come back on a tag that is actually in flight
  property pRetireOnBusyTag;
    @(posedge clk) disable iff (rst) fpu_valid_i |-> tagBusy[fpu_tag_i];
  endproperty
  aRetireOnBusyTag: assert property (pRetireOnBusyTag);

endmodule

// File: tb/tb_wired_fpu_share_arb.sv
// Bench for the FPU share arbiter: directed scenarios with literal
// expectations, then randomized traffic against a per-tag behavioural model.
module tb_wired_fpu_share_arb;
  import wired_fpu_share_arb_pkg::*;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               flush_i;
  logic [REQ_CNT-1:0] req_valid_i;
  logic [REQ_CNT-1:0] req_ready_o;
  iq_fpu_req_t        req_i [REQ_CNT];
  logic [REQ_CNT-1:0] resp_valid_o;
  logic [REQ_CNT-1:0] resp_ready_i;
  iq_fpu_resp_t       resp_o;
  logic               fpu_valid_o;
  logic               fpu_ready_i;
  iq_fpu_req_t        fpu_req_o;
  fpu_tag_t           fpu_tag_o;
  logic               fpu_valid_i;
  logic               fpu_ready_o;
  iq_fpu_resp_t       fpu_resp_i;
  fpu_tag_t           fpu_tag_i;
  logic               busy_o;

  int checks = 0;
  int errors = 0;

  wired_fpu_share_arb dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_i(req_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i), .resp_o(resp_o),
    .fpu_valid_o(fpu_valid_o), .fpu_ready_i(fpu_ready_i), .fpu_req_o(fpu_req_o),
    .fpu_tag_o(fpu_tag_o), .fpu_valid_i(fpu_valid_i), .fpu_ready_o(fpu_ready_o),
    .fpu_resp_i(fpu_resp_i), .fpu_tag_i(fpu_tag_i), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  // Behavioural model: one record per tag plus the pending (unaccepted) offer
  typedef struct {
    bit inflight;
    int owner;
    bit stale;
  } tagRec_t;

  tagRec_t tagRec [MAX_OUTSTANDING];
  int      lastGrant;
  bit      pendValid;
  int      pendIdx;
  int      pendTag;

  logic               expFpuValid;
  int                 expGrant;
  int                 expTag;
  logic [REQ_CNT-1:0] expReqReady;
  logic [REQ_CNT-1:0] expRespValid;
  logic               expFpuReady;
  logic               expBusy;

  // FPU-side stand-in: tags it has accepted, and the result it is presenting
  int fpuQ[$];
  bit fpuHold = 1'b0;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic pin(input string name, input logic [127:0] dutVal, input logic [127:0] modelVal,
                     input logic [127:0] lit);
    checkOutput({name, "_dut"}, dutVal, lit);
    checkOutput({name, "_model"}, modelVal, lit);
  endtask

  task automatic resetModel();
    for (int i = 0; i < MAX_OUTSTANDING; i++) tagRec[i] = '{inflight: 1'b0, owner: 0, stale: 1'b0};
    lastGrant = REQ_CNT - 1;
    pendValid = 1'b0;
    pendIdx   = 0;
    pendTag   = 0;
    fpuQ.delete();
    fpuHold   = 1'b0;
  endtask

  task automatic computeExpected();
    int nIn;
    int freeTag;
    int t;
    nIn     = 0;
    freeTag = -1;
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      if (tagRec[i].inflight) nIn++;
      else if (freeTag < 0) freeTag = i;
    end
    expBusy  = (nIn != 0);
    expGrant = -1;
    if (pendValid) begin
      if (req_valid_i[pendIdx]) expGrant = pendIdx;
    end else begin
      for (int k = 0; k < REQ_CNT; k++) begin
        int idx;
        idx = (lastGrant + 1 + k) % REQ_CNT;
        if (expGrant < 0 && req_valid_i[idx]) expGrant = idx;
      end
    end
    expFpuValid = !flush_i && (nIn < MAX_OUTSTANDING) && (expGrant >= 0);
    expTag      = pendValid ? pendTag : freeTag;
    expReqReady = '0;
    if (expFpuValid && fpu_ready_i) expReqReady[expGrant] = 1'b1;
    t            = int'(fpu_tag_i);
    expRespValid = '0;
    if (tagRec[t].inflight && !tagRec[t].stale) begin
      expRespValid[tagRec[t].owner] = fpu_valid_i;
      expFpuReady = resp_ready_i[tagRec[t].owner];
    end else if (tagRec[t].inflight) begin
      expFpuReady = 1'b1;
    end else begin
      expFpuReady = fpu_valid_i;
    end
  endtask

  task automatic updateModel();
    if (flush_i) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) if (tagRec[i].inflight) tagRec[i].stale = 1'b1;
      pendValid = 1'b0;
    end
    if (fpu_valid_i && expFpuReady) begin
      tagRec[int'(fpu_tag_i)].inflight = 1'b0;
      fpuHold = 1'b0;
    end
    if (expFpuValid) begin
      if (fpu_ready_i) begin
        tagRec[expTag] = '{inflight: 1'b1, owner: expGrant, stale: 1'b0};
        lastGrant = expGrant;
        pendValid = 1'b0;
        fpuQ.push_back(expTag);
      end else begin
        pendValid = 1'b1;
        pendIdx   = expGrant;
        pendTag   = expTag;
      end
    end
  endtask

  // Single compare process: every cycle, DUT against model, then advance model
  always @(negedge clk) begin
    if (rst) begin
      checkOutput("rst_fpu_valid_o", fpu_valid_o, 1'b0);
      checkOutput("rst_req_ready_o", req_ready_o, '0);
      checkOutput("rst_resp_valid_o", resp_valid_o, '0);
      checkOutput("rst_busy_o", busy_o, 1'b0);
      checkOutput("rst_fpu_ready_o", fpu_ready_o, 1'b0);
      resetModel();
    end else begin
      computeExpected();
      checkOutput("fpu_valid_o", fpu_valid_o, expFpuValid);
      checkOutput("req_ready_o", req_ready_o, expReqReady);
      checkOutput("busy_o", busy_o, expBusy);
      checkOutput("resp_valid_o", resp_valid_o, expRespValid);
      checkOutput("fpu_ready_o", fpu_ready_o, expFpuReady);
      if (expFpuValid) begin
        checkOutput("fpu_tag_o", fpu_tag_o, expTag);
        checkOutput("fpu_req_o", fpu_req_o, req_i[expGrant]);
      end
      if (expRespValid != '0) checkOutput("resp_o", resp_o, fpu_resp_i);
      updateModel();
    end
  end

  task automatic driveIdle();
    flush_i      = 1'b0;
    req_valid_i  = '0;
    resp_ready_i = '0;
    fpu_ready_i  = 1'b0;
    fpu_valid_i  = 1'b0;
    fpu_tag_i    = '0;
  endtask

  task automatic resetDut();
    @(posedge clk);
    #1;
    driveIdle();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Drive one cycle of directed inputs, then settle past the compare edge
  task automatic applyStimulus(input logic [REQ_CNT-1:0] reqValid, input logic fpuReady,
                               input logic [REQ_CNT-1:0] respReady, input logic flush,
                               input logic fpuValid, input int fpuTag);
    @(posedge clk);
    #1;
    req_valid_i  = reqValid;
    fpu_ready_i  = fpuReady;
    resp_ready_i = respReady;
    flush_i      = flush;
    fpu_valid_i  = fpuValid;
    fpu_tag_i    = fpu_tag_t'(fpuTag);
    fpu_resp_i.result = $urandom;
    @(negedge clk);
    #1;
  endtask

  task automatic driveRandom();
    for (int i = 0; i < REQ_CNT; i++) begin
      if (pendValid && pendIdx == i) begin
        req_valid_i[i] = 1'b1;
      end else begin
        req_valid_i[i]     = ($urandom_range(0, 9) < 6);
        req_i[i].op        = 4'($urandom_range(0, 15));
        req_i[i].rm        = 3'($urandom_range(0, 7));
        req_i[i].rs1       = $urandom;
        req_i[i].rs2       = $urandom;
        req_i[i].robId     = 6'($urandom_range(0, 63));
      end
    end
    fpu_ready_i  = ($urandom_range(0, 9) < 7);
    resp_ready_i = REQ_CNT'($urandom_range(0, (1 << REQ_CNT) - 1)) | REQ_CNT'($urandom_range(0, (1 << REQ_CNT) - 1));
    flush_i      = ($urandom_range(0, 39) == 0);
    if (!fpuHold) begin
      if (fpuQ.size() > 0 && $urandom_range(0, 1) == 1) begin
        int pick;
        pick = $urandom_range(0, fpuQ.size() - 1);
        fpu_tag_i = fpu_tag_t'(fpuQ[pick]);
        fpuQ.delete(pick);
        fpuHold            = 1'b1;
        fpu_valid_i        = 1'b1;
        fpu_resp_i.result  = $urandom;
        fpu_resp_i.fflags  = 5'($urandom_range(0, 31));
        fpu_resp_i.robId   = 6'($urandom_range(0, 63));
        fpu_resp_i.tag     = fpu_tag_i;
      end else begin
        fpu_valid_i = 1'b0;
        fpu_tag_i   = fpu_tag_t'($urandom_range(0, MAX_OUTSTANDING - 1));
      end
    end
  endtask

  initial begin
    driveIdle();
    fpu_resp_i = '0;
    for (int i = 0; i < REQ_CNT; i++) req_i[i] = '0;
    req_i[FPU_ARB_REQ_OOO].op = 4'd1;
    req_i[FPU_ARB_REQ_INO].op = 4'd2;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Single issue and return
    applyStimulus(2'b01, 1'b1, 2'b00, 1'b0, 1'b0, 0);
    pin("single_tag", fpu_tag_o, expTag, 0);
    pin("single_ready", req_ready_o, expReqReady, 2'b01);
    applyStimulus(2'b00, 1'b0, 2'b11, 1'b0, 1'b1, 0);
    pin("single_resp", resp_valid_o, expRespValid, 2'b01);
    pin("single_busy1", busy_o, expBusy, 1'b1);
    applyStimulus(2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 0);
    pin("single_busy0", busy_o, expBusy, 1'b0);

    // Round-robin fill, then full
    resetDut();
    for (int c = 0; c < 4; c++) begin
      applyStimulus(2'b11, 1'b1, 2'b00, 1'b0, 1'b0, 0);
      pin($sformatf("rr_ready%0d", c), req_ready_o, expReqReady, (c % 2 == 0) ? 2'b01 : 2'b10);
      pin($sformatf("rr_tag%0d", c), fpu_tag_o, expTag, c);
    end
    applyStimulus(2'b11, 1'b1, 2'b00, 1'b0, 1'b0, 0);
    pin("full_valid", fpu_valid_o, expFpuValid, 1'b0);

    // Out-of-order return, then lowest freed tag reused
    applyStimulus(2'b00, 1'b0, 2'b11, 1'b0, 1'b1, 2);
    pin("ooo_t2", resp_valid_o, expRespValid, 2'b01);
    applyStimulus(2'b00, 1'b0, 2'b11, 1'b0, 1'b1, 0);
    pin("ooo_t0", resp_valid_o, expRespValid, 2'b01);
    applyStimulus(2'b01, 1'b1, 2'b00, 1'b0, 1'b0, 0);
    pin("ooo_realloc", fpu_tag_o, expTag, 0);
    applyStimulus(2'b00, 1'b0, 2'b11, 1'b0, 1'b1, 3);
    pin("ooo_t3", resp_valid_o, expRespValid, 2'b10);
    applyStimulus(2'b00, 1'b0, 2'b11, 1'b0, 1'b1, 1);
    pin("ooo_t1", resp_valid_o, expRespValid, 2'b10);

    // Lock holds grant and tag while the FPU stalls
    resetDut();
    applyStimulus(2'b01, 1'b1, 2'b00, 1'b0, 1'b0, 0);
    applyStimulus(2'b11, 1'b0, 2'b00, 1'b0, 1'b0, 0);
    pin("lock_op", fpu_req_o.op, req_i[expGrant].op, 4'd2);
    pin("lock_tag1", fpu_tag_o, expTag, 1);
    applyStimulus(2'b11, 1'b0, 2'b11, 1'b0, 1'b1, 0);
    pin("lock_ready", req_ready_o, expReqReady, 2'b00);
    applyStimulus(2'b11, 1'b0, 2'b00, 1'b0, 1'b0, 0);
    pin("lock_tag3", fpu_tag_o, expTag, 1);
    applyStimulus(2'b11, 1'b1, 2'b00, 1'b0, 1'b0, 0);
    pin("lock_hs", req_ready_o, expReqReady, 2'b10);
    applyStimulus(2'b11, 1'b1, 2'b00, 1'b0, 1'b0, 0);
    pin("lock_next", req_ready_o, expReqReady, 2'b01);
    pin("lock_next_tag", fpu_tag_o, expTag, 0);

    // Flush orphans in-flight ops; their results are dropped
    resetDut();
    repeat (3) applyStimulus(2'b01, 1'b1, 2'b00, 1'b0, 1'b0, 0);
    applyStimulus(2'b01, 1'b1, 2'b00, 1'b1, 1'b0, 0);
    pin("flush_valid", fpu_valid_o, expFpuValid, 1'b0);
    applyStimulus(2'b01, 1'b1, 2'b00, 1'b0, 1'b0, 0);
    pin("flush_newtag", fpu_tag_o, expTag, 3);
    for (int t = 0; t < 3; t++) begin
      applyStimulus(2'b00, 1'b0, 2'b00, 1'b0, 1'b1, t);
      pin($sformatf("flush_drop%0d", t), resp_valid_o, expRespValid, 2'b00);
      pin($sformatf("flush_rdy%0d", t), fpu_ready_o, expFpuReady, 1'b1);
    end
    applyStimulus(2'b00, 1'b0, 2'b01, 1'b0, 1'b1, 3);
    pin("flush_live", resp_valid_o, expRespValid, 2'b01);
    applyStimulus(2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 0);
    pin("flush_idle", busy_o, expBusy, 1'b0);

    // Response backpressure
    resetDut();
    repeat (2) applyStimulus(2'b01, 1'b1, 2'b00, 1'b0, 1'b0, 0);
    repeat (2) begin
      applyStimulus(2'b00, 1'b0, 2'b00, 1'b0, 1'b1, 1);
      pin("bp_hold", fpu_ready_o, expFpuReady, 1'b0);
      pin("bp_valid", resp_valid_o, expRespValid, 2'b01);
    end
    applyStimulus(2'b00, 1'b0, 2'b01, 1'b0, 1'b1, 1);
    pin("bp_release", fpu_ready_o, expFpuReady, 1'b1);
    applyStimulus(2'b01, 1'b1, 2'b00, 1'b0, 1'b0, 0);
    pin("bp_reuse", fpu_tag_o, expTag, 1);

    // Randomized traffic with a mid-run reset
    resetDut();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc == 1500) begin
        resetDut();
      end else begin
        @(posedge clk);
        #1;
        driveRandom();
      end
    end
    @(posedge clk);
    #1;
    driveIdle();
    repeat (2) @(posedge clk);
    $display("[TB] random phase complete");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
